// File: rtl/sad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sad_pkg
// Brief    : Shared constants, result-width helper and output FSM states.
// Revision : 1.0
// ============================================================================
package sad_pkg;

    localparam int DIFF_W = 9;

    // Widest block sum is (2^diff_w - 1) * len, which always fits this width.
    function automatic int sum_width(input int diff_w, input int len);
        return diff_w + $clog2(len);
    endfunction

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sad_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : sad_accumulator_if
// Brief    : Abs-diff input stream, clear and block-SAD result handshake.
// Revision : 1.0
// ============================================================================
interface sad_accumulator_if #(
    parameter int DIFF_W = 9,
    parameter int SUM_W  = 13
);
    logic              in_valid;
    logic              in_ready;
    logic [DIFF_W-1:0] diff_in;
    logic              clear;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  sad_out;
    logic [15:0]       blk_cnt;

    modport master (
        output in_valid, diff_in, clear, out_ready,
        input  in_ready, out_valid, sad_out, blk_cnt
    );

    modport slave (
        input  in_valid, diff_in, clear, out_ready,
        output in_ready, out_valid, sad_out, blk_cnt
    );
endinterface
`default_nettype wire

// File: rtl/sad_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : sad_out_reg
// Brief    : Valid/ready holding register for block results, with in_ready.
// Revision : 1.0
// ============================================================================
module sad_out_reg
    import sad_pkg::*;
#(
    parameter int SUM_W = 13
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             final_beat,
    input  wire logic [SUM_W-1:0] sum_in,
    input  wire logic             out_ready,
    output logic                  out_valid,
    output logic [SUM_W-1:0]      sad_out,
    output logic                  in_ready
);

    state_t           r_state;
    logic             r_out_valid;
    logic [SUM_W-1:0] r_sad_out;

    // A final beat can only arrive in HOLD when the consumer is taking the
    // current result, so replacing it in place gives one sample per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ACCUM;
            r_out_valid <= 1'b0;
            r_sad_out   <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (final_beat) begin
                        r_state     <= HOLD;
                        r_out_valid <= 1'b1;
                        r_sad_out   <= sum_in;
                    end
                end
                HOLD: begin
                    if (final_beat) begin
                        r_sad_out <= sum_in;
                    end else if (out_ready) begin
                        r_state     <= ACCUM;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ACCUM;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign sad_out   = r_sad_out;
    assign in_ready  = ~r_out_valid | out_ready;

endmodule
`default_nettype wire

// File: rtl/sad_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : sad_accumulator
// Brief    : Accumulates BLOCK_LEN abs-diff samples into one block SAD.
// Revision : 1.0
// ============================================================================
module sad_accumulator
    import sad_pkg::*;
#(
    parameter int BLOCK_LEN = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    sad_accumulator_if.slave bus
);

    localparam int CNT_W = $clog2(BLOCK_LEN);
    localparam int SUM_W = sum_width(DIFF_W, BLOCK_LEN);
    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(BLOCK_LEN - 1);

    logic [SUM_W-1:0] r_acc;
    logic [CNT_W-1:0] r_idx;
    logic [15:0]      r_blk_cnt;

    logic             w_in_ready;
    logic             w_take;
    logic             w_final;
    logic [SUM_W-1:0] w_sum;

    // A beat coinciding with clear is handshaken but discarded.
    assign w_take  = bus.in_valid & w_in_ready & ~bus.clear;
    assign w_final = w_take & (r_idx == c_last_idx);
    assign w_sum   = r_acc + SUM_W'(bus.diff_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_idx     <= '0;
            r_blk_cnt <= '0;
        end else if (bus.clear) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (w_take) begin
            if (w_final) begin
                r_acc     <= '0;
                r_idx     <= '0;
                r_blk_cnt <= r_blk_cnt + 16'd1;
            end else begin
                r_acc <= w_sum;
                r_idx <= r_idx + CNT_W'(1);
            end
        end
    end

    sad_out_reg #(
        .SUM_W (SUM_W)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .final_beat (w_final),
        .sum_in     (w_sum),
        .out_ready  (bus.out_ready),
        .out_valid  (bus.out_valid),
        .sad_out    (bus.sad_out),
        .in_ready   (w_in_ready)
    );

    assign bus.in_ready = w_in_ready;
    assign bus.blk_cnt  = r_blk_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sad_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sad_accumulator
// Brief    : Directed self-checking bench for sad_accumulator (lengths 4, 256).
// Revision : 1.0
// ============================================================================
module tb_sad_accumulator;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    sad_accumulator_if #(.DIFF_W(9), .SUM_W(11)) bus4   ();
    sad_accumulator_if #(.DIFF_W(9), .SUM_W(17)) bus256 ();

    sad_accumulator #(.BLOCK_LEN(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    sad_accumulator #(.BLOCK_LEN(256)) dut256 (
        .clk (clk),
        .rst (rst),
        .bus (bus256)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic beat4(input int d);
        bus4.in_valid = 1'b1;
        bus4.diff_in  = 9'(d);
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus4.in_valid   = 1'b0;
        bus4.diff_in    = '0;
        bus4.clear      = 1'b0;
        bus4.out_ready  = 1'b1;
        bus256.in_valid  = 1'b0;
        bus256.diff_in   = '0;
        bus256.clear     = 1'b0;
        bus256.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;

        check("reset_out_valid", 32'(bus4.out_valid), 0);
        check("reset_sad_out",   32'(bus4.sad_out),   0);
        check("reset_blk_cnt",   32'(bus4.blk_cnt),   0);
        check("reset_in_ready",  32'(bus4.in_ready),  1);

        // Single block, exact one-cycle latency
        beat4(10);
        beat4(20);
        beat4(30);
        check("b1_not_early", 32'(bus4.out_valid), 0);
        beat4(40);
        check("b1_valid", 32'(bus4.out_valid), 1);
        check("b1_sum",   32'(bus4.sad_out),   100);
        check("b1_cnt",   32'(bus4.blk_cnt),   1);

        // Two back-to-back blocks at full throughput
        for (int i = 1; i <= 8; i++) begin
            bus4.in_valid = 1'b1;
            bus4.diff_in  = 9'(i);
            #1;
            check("b2_in_ready", 32'(bus4.in_ready), 1);
            tick();
            if (i == 4) begin
                check("b2_valid_a", 32'(bus4.out_valid), 1);
                check("b2_sum_a",   32'(bus4.sad_out),   10);
                check("b2_cnt_a",   32'(bus4.blk_cnt),   2);
            end
        end
        check("b2_valid_b", 32'(bus4.out_valid), 1);
        check("b2_sum_b",   32'(bus4.sad_out),   26);
        check("b2_cnt_b",   32'(bus4.blk_cnt),   3);

        bus4.in_valid = 1'b0;
        tick();
        check("drain_valid", 32'(bus4.out_valid), 0);
        check("drain_hold",  32'(bus4.sad_out),   26);

        // Backpressure with in_valid held high
        bus4.out_ready = 1'b0;
        beat4(10);
        beat4(20);
        beat4(30);
        beat4(40);
        check("bp_valid", 32'(bus4.out_valid), 1);
        check("bp_cnt",   32'(bus4.blk_cnt),   4);
        bus4.in_valid = 1'b1;
        bus4.diff_in  = 9'd1;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 32'(bus4.in_ready),  0);
            check("bp_sum",      32'(bus4.sad_out),   100);
            check("bp_stable_v", 32'(bus4.out_valid), 1);
            tick();
        end
        bus4.out_ready = 1'b1;
        #1;
        check("bp_release_rdy", 32'(bus4.in_ready), 1);
        tick();
        check("bp_consumed", 32'(bus4.out_valid), 0);
        beat4(2);
        beat4(3);
        check("bp_not_early", 32'(bus4.out_valid), 0);
        beat4(4);
        check("bp_next_valid", 32'(bus4.out_valid), 1);
        check("bp_next_sum",   32'(bus4.sad_out),   10);
        check("bp_next_cnt",   32'(bus4.blk_cnt),   5);

        // Clear drops the partial block and the coincident beat
        beat4(7);
        beat4(7);
        bus4.clear    = 1'b1;
        bus4.in_valid = 1'b1;
        bus4.diff_in  = 9'd7;
        #1;
        check("clr_in_ready", 32'(bus4.in_ready), 1);
        tick();
        bus4.clear = 1'b0;
        check("clr_keeps_cnt", 32'(bus4.blk_cnt), 5);
        beat4(1);
        beat4(1);
        beat4(1);
        check("clr_not_early", 32'(bus4.out_valid), 0);
        beat4(1);
        check("clr_valid", 32'(bus4.out_valid), 1);
        check("clr_sum",   32'(bus4.sad_out),   4);
        check("clr_cnt",   32'(bus4.blk_cnt),   6);

        // Asynchronous reset mid-block
        beat4(3);
        beat4(3);
        bus4.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus4.out_valid), 0);
        check("arst_sum",   32'(bus4.sad_out),   0);
        check("arst_cnt",   32'(bus4.blk_cnt),   0);
        tick();
        rst = 1'b0;
        #1;
        check("arst_in_ready", 32'(bus4.in_ready), 1);
        beat4(3);
        beat4(3);
        beat4(3);
        check("arst_not_early", 32'(bus4.out_valid), 0);
        beat4(3);
        check("arst_valid2", 32'(bus4.out_valid), 1);
        check("arst_sum2",   32'(bus4.sad_out),   12);
        check("arst_cnt2",   32'(bus4.blk_cnt),   1);
        bus4.in_valid = 1'b0;

        // Maximal block at BLOCK_LEN=256
        bus256.in_valid = 1'b1;
        bus256.diff_in  = 9'd511;
        for (int i = 0; i < 255; i++) begin
            tick();
        end
        check("max_not_early", 32'(bus256.out_valid), 0);
        tick();
        bus256.in_valid = 1'b0;
        check("max_valid", 32'(bus256.out_valid), 1);
        check("max_sum",   32'(bus256.sad_out),   130816);
        check("max_cnt",   32'(bus256.blk_cnt),   1);
        tick();
        check("max_drain", 32'(bus256.out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
